// File: rtl/data_mem_pkg.sv
// Shared types and default widths for the data memory and its neighbours.
//   DM_DW / DM_AW : default data and address widths (shared with ALU and register file)
//   dm_state_t    : sequencer state (INIT sweep, RUN)
package data_mem_pkg;

  localparam int unsigned DM_DW = 8;
  localparam int unsigned DM_AW = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dm_state_t;

endpackage

// File: rtl/data_mem_seq_if.sv
// Load/store bus between the processor and the data memory.
//   master : drives DataAddress, ReadMem, WriteMem, DataIn
//   slave  : drives DataOut, DataValid, Ready, AddrErr
interface data_mem_seq_if
  import data_mem_pkg::*;
#(
  parameter int unsigned DW = DM_DW,
  parameter int unsigned AW = DM_AW
);

  logic [AW-1:0] DataAddress;
  logic          ReadMem;
  logic          WriteMem;
  logic [DW-1:0] DataIn;
  logic [DW-1:0] DataOut;
  logic          DataValid;
  logic          Ready;
  logic          AddrErr;

  modport master (
    output DataAddress, ReadMem, WriteMem, DataIn,
    input  DataOut, DataValid, Ready, AddrErr
  );

  modport slave (
    input  DataAddress, ReadMem, WriteMem, DataIn,
    output DataOut, DataValid, Ready, AddrErr
  );

endinterface

// File: rtl/data_mem_core.sv
// Plain DW x DEPTH storage: one synchronous write port, one registered read port.
// A same-edge read and write to one address returns the old contents.
// No reset so the array maps onto block RAM.
//   clk         : clock
//   we/waddr/wdata : write port
//   re/raddr    : read enable and address
//   rdata       : registered read data (holds when re=0)
module data_mem_core #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Non-blocking write and read on the same edge give read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_seq.sv
// Data memory with power-up clear sweep, registered reads and range checking.
//   CLK   : clock
//   reset : synchronous active-high reset; restarts the clear sweep
//   bus   : load/store slave port (address, read/write requests, data, strobes)
module data_mem_seq
  import data_mem_pkg::*;
#(
  parameter int unsigned   DW      = DM_DW,
  parameter int unsigned   AW      = DM_AW,
  parameter int unsigned   DEPTH   = 2 ** AW,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic           CLK,
  input  logic           reset,
  data_mem_seq_if.slave  bus
);

  localparam int unsigned IW       = $clog2(DEPTH);
  localparam bit          FULL_MAP = (DEPTH == (2 ** AW));

  dm_state_t     state_q,     state_d;
  logic [IW-1:0] init_cnt_q,  init_cnt_d;
  logic          ready_q,     ready_d;
  logic          valid_q,     valid_d;
  logic          oor_rd_q,    oor_rd_d;
  logic          addr_err_q,  addr_err_d;
  logic [DW-1:0] dout_hold_q, dout_hold_d;

  logic          addr_oor_c;
  logic [IW-1:0] idx_c;
  logic          mem_we_c;
  logic          mem_re_c;
  logic [IW-1:0] mem_waddr_c;
  logic [DW-1:0] mem_wdata_c;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] data_out_c;

  // Range check on the full address; vanishes when every address is implemented.
  if (FULL_MAP) begin : g_full_map
    assign addr_oor_c = 1'b0;
  end else begin : g_part_map
    assign addr_oor_c = (bus.DataAddress >= AW'(DEPTH));
  end

  assign idx_c = IW'(bus.DataAddress);

  data_mem_core #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_core (
    .clk   (CLK),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .wdata (mem_wdata_c),
    .re    (mem_re_c),
    .raddr (idx_c),
    .rdata (mem_rdata)
  );

  // Read result: RAM data, forced zero for an out-of-range read, else last value held.
  always_comb begin
    data_out_c = dout_hold_q;
    if (valid_q) begin
      data_out_c = oor_rd_q ? '0 : mem_rdata;
    end
  end

  // Sequencer: clear sweep, then request decode and write-port mux.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ready_d     = ready_q;
    valid_d     = 1'b0;
    oor_rd_d    = 1'b0;
    addr_err_d  = 1'b0;
    dout_hold_d = dout_hold_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_waddr_c = idx_c;
    mem_wdata_c = bus.DataIn;

    if (valid_q) begin
      dout_hold_d = data_out_c;
    end

    case (state_q)
      INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = init_cnt_q;
        mem_wdata_c = CLR_VAL;
        if (init_cnt_q == IW'(DEPTH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      RUN: begin
        if (bus.ReadMem || bus.WriteMem) begin
          if (addr_oor_c) begin
            addr_err_d = 1'b1;
            valid_d    = bus.ReadMem;
            oor_rd_d   = bus.ReadMem;
          end else begin
            mem_we_c = bus.WriteMem;
            mem_re_c = bus.ReadMem;
            valid_d  = bus.ReadMem;
          end
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Reset aborts any in-flight access, including a sweep write.
    if (reset) begin
      mem_we_c = 1'b0;
      mem_re_c = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      oor_rd_q    <= 1'b0;
      addr_err_q  <= 1'b0;
      dout_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      oor_rd_q    <= oor_rd_d;
      addr_err_q  <= addr_err_d;
      dout_hold_q <= dout_hold_d;
    end
  end

  assign bus.DataOut   = data_out_c;
  assign bus.DataValid = valid_q;
  assign bus.Ready     = ready_q;
  assign bus.AddrErr   = addr_err_q;

endmodule

// File: tb/tb_data_mem_seq.sv
// Scoreboard bench for data_mem_seq: a DEPTH=200 instance with a reference memory
// model, plus a fully mapped DEPTH=256 instance that must never flag AddrErr.
module tb_data_mem_seq;

  localparam int unsigned DEPTH0 = 200;
  localparam int unsigned DEPTH1 = 256;
  localparam logic [7:0]  CLR0   = 8'hA5;

  typedef struct {
    int         due;
    logic       v;
    logic       e;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_seq_if #(.DW(8), .AW(8)) b0 ();
  data_mem_seq_if #(.DW(8), .AW(8)) b1 ();

  data_mem_seq #(.DW(8), .AW(8), .DEPTH(DEPTH0), .CLR_VAL(CLR0)) u_dut0 (
    .CLK   (clk),
    .reset (rst),
    .bus   (b0.slave)
  );

  data_mem_seq #(.DW(8), .AW(8), .DEPTH(DEPTH1), .CLR_VAL(8'h00)) u_dut1 (
    .CLK   (clk),
    .reset (rst),
    .bus   (b1.slave)
  );

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         cyc       = 0;
  int         ready_at  = 32'h7fff_ffff;
  int         ready1_at = 32'h7fff_ffff;
  bit         chk_en    = 1'b0;
  logic [7:0] exp_mem [DEPTH0];
  exp_t       sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Per-cycle monitor: Ready timing, idle strobes, and in-order scoreboard responses.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      chk("ready0", 32'(b0.Ready), 32'(cyc >= ready_at));
      chk("ready1", 32'(b1.Ready), 32'(cyc >= ready1_at));
      chk("addr_err1_never", 32'(b1.AddrErr), 32'(0));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("resp_valid", 32'(b0.DataValid), 32'(e.v));
        chk("resp_addr_err", 32'(b0.AddrErr), 32'(e.e));
        if (e.v) chk("resp_data", 32'(b0.DataOut), 32'(e.d));
      end else begin
        chk("idle_valid", 32'(b0.DataValid), 32'(0));
        chk("idle_addr_err", 32'(b0.AddrErr), 32'(0));
      end
    end
  end

  task automatic idle_inputs();
    b0.ReadMem = 1'b0; b0.WriteMem = 1'b0;
    b1.ReadMem = 1'b0; b1.WriteMem = 1'b0;
  endtask

  // One-cycle reset pulse; the sweep starts on the edge after it is released.
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    ready_at  = cyc + int'(DEPTH0);
    ready1_at = cyc + int'(DEPTH1);
    for (int i = 0; i < int'(DEPTH0); i++) exp_mem[i] = CLR0;
    sb.delete();
  endtask

  // Drive one request to DUT0 for a single cycle and record the expected response.
  task automatic req(input logic rd, input logic wr, input int addr, input logic [7:0] din);
    exp_t e;
    @(posedge clk); #1;
    b0.ReadMem     = rd;
    b0.WriteMem    = wr;
    b0.DataAddress = 8'(addr);
    b0.DataIn      = din;
    if (rd || wr) begin
      e.due = cyc + 1;
      if (addr >= int'(DEPTH0)) begin
        e.v = rd; e.e = 1'b1; e.d = 8'h00;
        sb.push_back(e);
      end else begin
        if (rd) begin
          e.v = 1'b1; e.e = 1'b0; e.d = exp_mem[addr];
          sb.push_back(e);
        end
        if (wr) exp_mem[addr] = din;
      end
    end
  endtask

  task automatic idle0(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      b0.ReadMem = 1'b0; b0.WriteMem = 1'b0;
    end
  endtask

  // Single access on DUT1, checked directly on the response cycle.
  task automatic d1_op(input logic rd, input logic wr, input int addr,
                       input logic [7:0] din, input logic [7:0] exp_d);
    @(posedge clk); #1;
    b1.ReadMem     = rd;
    b1.WriteMem    = wr;
    b1.DataAddress = 8'(addr);
    b1.DataIn      = din;
    @(posedge clk);
    @(negedge clk);
    chk("d1_valid", 32'(b1.DataValid), 32'(rd));
    chk("d1_addr_err", 32'(b1.AddrErr), 32'(0));
    if (rd) chk("d1_data", 32'(b1.DataOut), 32'(exp_d));
    #1;
    b1.ReadMem = 1'b0; b1.WriteMem = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    b0.DataAddress = '0; b0.DataIn = '0;
    b1.DataAddress = '0; b1.DataIn = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_at  = cyc + int'(DEPTH0);
    ready1_at = cyc + int'(DEPTH1);
    for (int i = 0; i < int'(DEPTH0); i++) exp_mem[i] = CLR0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_data_out", 32'(b0.DataOut), 32'(0));
    chk("rst_valid", 32'(b0.DataValid), 32'(0));
    chk("rst_ready", 32'(b0.Ready), 32'(0));
    chk("rst_addr_err", 32'(b0.AddrErr), 32'(0));

    // Sweep completion, then cleared words at both ends.
    while (cyc < ready_at) @(posedge clk);
    req(1'b1, 1'b0, 0, 8'h00);
    req(1'b1, 1'b0, 199, 8'h00);
    idle0(2);

    // Write then read back.
    req(1'b0, 1'b1, 17, 8'h3C);
    req(1'b1, 1'b0, 17, 8'h00);
    idle0(2);

    // Same-cycle read and write returns old data.
    req(1'b1, 1'b1, 17, 8'h77);
    req(1'b1, 1'b0, 17, 8'h00);
    idle0(2);

    // Out-of-range write is dropped, out-of-range read returns zero with AddrErr.
    req(1'b0, 1'b1, 230, 8'hFF);
    req(1'b1, 1'b0, 230, 8'h00);
    req(1'b1, 1'b0, 30, 8'h00);
    idle0(2);

    // Reset 50 cycles into a sweep; requests during INIT are ignored.
    apply_reset();
    repeat (49) @(posedge clk);
    apply_reset();
    repeat (5) begin
      @(posedge clk); #1;
      b0.ReadMem = 1'b1; b0.DataAddress = 8'd3;
      @(posedge clk); #1;
      b0.ReadMem = 1'b0;
    end
    @(posedge clk); #1;
    b0.WriteMem = 1'b1; b0.DataAddress = 8'd5; b0.DataIn = 8'h11;
    @(posedge clk); #1;
    b0.WriteMem = 1'b0;
    while (cyc < ready_at) @(posedge clk);
    req(1'b1, 1'b0, 5, 8'h00);
    req(1'b1, 1'b0, 17, 8'h00);
    idle0(2);

    // Back-to-back writes then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) req(1'b0, 1'b1, i, 8'(i));
    for (int i = 0; i < 16; i++) req(1'b1, 1'b0, i, 8'h00);
    idle0(3);

    // Fully mapped instance: top addresses are legal and never flag AddrErr.
    while (cyc < ready1_at) @(posedge clk);
    d1_op(1'b1, 1'b0, 230, 8'h00, 8'h00);
    d1_op(1'b0, 1'b1, 255, 8'h5A, 8'h00);
    d1_op(1'b1, 1'b0, 255, 8'h00, 8'h5A);
    d1_op(1'b1, 1'b0, 199, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
